framebuffer_writer: RTL and testbench



---
 rtl/framebuffer_writer_pkg.sv | 9 +
 rtl/framebuffer_writer_if.sv | 13 +
 rtl/framebuffer_writer_rect_scanner.sv | 39 +++
 rtl/framebuffer_writer.sv | 70 +++++++
 tb/tb_framebuffer_writer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/framebuffer_writer_pkg.sv
// framebuffer_writer_pkg: shared geometry, opcodes and FSM encoding for the framebuffer writer
package framebuffer_writer_pkg;
   localparam int FB_X_W = 6;
   localparam int FB_Y_W = 6;
   localparam int IMG_W = 1 << FB_X_W;
   localparam int IMG_H = 1 << FB_Y_W;
   typedef enum logic [1:0] {OP_NOP = 2'b00, OP_PIXEL = 2'b01, OP_RECT = 2'b10, OP_CLEAR = 2'b11} op_e;
   typedef enum logic [1:0] {S_IDLE, S_WRITE1, S_FILL, S_DONE} state_e;
endpackage

// File: rtl/framebuffer_writer_if.sv
// framebuffer_writer_if: drawing command bus with valid/ready handshake
interface framebuffer_writer_if #(parameter int X_W = 6, parameter int Y_W = 6);
   logic valid;
   logic ready;
   logic [1:0] op;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic [X_W:0] w;
   logic [Y_W:0] h;
   logic color;
   modport master(output valid, op, x, y, w, h, color, input ready);
   modport slave(input valid, op, x, y, w, h, color, output ready);
endinterface

// File: rtl/framebuffer_writer_rect_scanner.sv
// rect_scanner: walks an already-clipped rectangle row-major, one coordinate per step
module rect_scanner #(parameter int X_W = 6, parameter int Y_W = 6) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   input  logic           step,
   input  logic [X_W-1:0] x0,
   input  logic [Y_W-1:0] y0,
   input  logic [X_W:0]   w,
   input  logic [Y_W:0]   h,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last
);
   logic [X_W-1:0] xs;
   logic [X_W:0] x_end;
   logic [Y_W:0] y_end;
   logic row_end;
   // ends are one bit wider so that a rectangle reaching the image edge does not overflow
   assign row_end = ({1'b0, x} + (X_W+1)'(1)) == x_end;
   assign last = row_end && (({1'b0, y} + (Y_W+1)'(1)) == y_end);
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         xs <= '0;
         x_end <= '0;
         y_end <= '0;
         x <= '0;
         y <= '0;
      end else if (start) begin
         xs <= x0;
         x_end <= {1'b0, x0} + w;
         y_end <= {1'b0, y0} + h;
         x <= x0;
         y <= y0;
      end else if (step) begin
         x <= row_end ? xs : x + X_W'(1);
         y <= row_end ? y + Y_W'(1) : y;
      end
endmodule

// File: rtl/framebuffer_writer.sv
// framebuffer_writer: executes pixel/rect/clear commands as one RAM write per clock
module framebuffer_writer import framebuffer_writer_pkg::*; #(
   parameter int X_W = FB_X_W,
   parameter int Y_W = FB_Y_W,
   parameter int ADDR_W = X_W + Y_W
) (
   input  logic              clock,
   input  logic              reset,
   framebuffer_writer_if.slave cmd,
   output logic [ADDR_W-1:0] wraddress,
   output logic              data,
   output logic              wren,
   output logic              busy,
   output logic              done
);
   localparam logic [X_W:0] full_w = (X_W+1)'(1) << X_W;
   localparam logic [Y_W:0] full_h = (Y_W+1)'(1) << Y_W;
   state_e state, state_n;
   logic accept, is_clear, zero, last, color_q, data_q;
   logic [ADDR_W-1:0] addr_q;
   logic [X_W:0] avail_w, w_eff, sw;
   logic [Y_W:0] avail_h, h_eff, sh;
   logic [X_W-1:0] sx, cx;
   logic [Y_W-1:0] sy, cy;
   assign cmd.ready = state == S_IDLE;
   assign accept = cmd.valid && cmd.ready;
   assign is_clear = cmd.op == OP_CLEAR;
   assign avail_w = full_w - {1'b0, cmd.x};
   assign avail_h = full_h - {1'b0, cmd.y};
   assign w_eff = cmd.w < avail_w ? cmd.w : avail_w;
   assign h_eff = cmd.h < avail_h ? cmd.h : avail_h;
   assign sx = is_clear ? '0 : cmd.x;
   assign sy = is_clear ? '0 : cmd.y;
   assign sw = is_clear ? full_w : w_eff;
   assign sh = is_clear ? full_h : h_eff;
   assign zero = sw == '0 || sh == '0;
   rect_scanner #(.X_W(X_W), .Y_W(Y_W)) scanner (
      .clock(clock), .reset(reset), .start(accept), .step(state == S_FILL),
      .x0(sx), .y0(sy), .w(sw), .h(sh), .x(cx), .y(cy), .last(last)
   );
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (accept) state_n = cmd.op == OP_PIXEL ? S_WRITE1 : (cmd.op == OP_NOP || zero) ? S_DONE : S_FILL;
         S_WRITE1: state_n = S_DONE;
         S_FILL:   state_n = last ? S_DONE : S_FILL;
         default:  state_n = S_IDLE;
      endcase
   end
   assign wren = state == S_WRITE1 || state == S_FILL;
   assign busy = state != S_IDLE;
   assign done = state == S_DONE;
   // the write port is combinational off the scanner; the hold registers keep it stable between commands
   assign wraddress = wren ? {cy, cx} : addr_q;
   assign data = wren ? color_q : data_q;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= S_IDLE;
         color_q <= 1'b0;
         addr_q <= '0;
         data_q <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) color_q <= cmd.color;
         if (wren) begin
            addr_q <= wraddress;
            data_q <= data;
         end
      end
endmodule

// File: tb/tb_framebuffer_writer.sv
// tb_framebuffer_writer: randomized command stream checked against a pixel-list reference model
module tb_framebuffer_writer;
   import framebuffer_writer_pkg::*;
   logic clock = 0, reset = 1;
   logic [11:0] wraddress;
   logic data, wren, busy, done;
   int checks = 0, failures = 0;
   framebuffer_writer_if #(.X_W(6), .Y_W(6)) cmd();
   framebuffer_writer dut (.clock(clock), .reset(reset), .cmd(cmd), .wraddress(wraddress),
                           .data(data), .wren(wren), .busy(busy), .done(done));
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic scramble();
      cmd.op = 2'($urandom);
      cmd.x = 6'($urandom);
      cmd.y = 6'($urandom);
      cmd.w = 7'($urandom);
      cmd.h = 7'($urandom);
      cmd.color = 1'($urandom);
   endtask

   task automatic run_cmd(input logic [1:0] op, input int x, input int y, input int w, input int h, input logic c);
      int ex[$];
      int x0, y0, ww, hh, idx, lat, ready_bad;
      bit got_done;
      x0 = op == OP_CLEAR ? 0 : x;
      y0 = op == OP_CLEAR ? 0 : y;
      ww = op == OP_CLEAR ? IMG_W : op == OP_PIXEL ? 1 : op == OP_RECT ? w : 0;
      hh = op == OP_CLEAR ? IMG_H : op == OP_PIXEL ? 1 : op == OP_RECT ? h : 0;
      for (int yy = y0; yy < y0 + hh && yy < IMG_H; yy++)
         for (int xx = x0; xx < x0 + ww && xx < IMG_W; xx++)
            ex.push_back((yy * IMG_W + xx) * 2 + int'(c));
      lat = ex.size() + 1;
      cmd.op = op; cmd.x = 6'(x); cmd.y = 6'(y); cmd.w = 7'(w); cmd.h = 7'(h); cmd.color = c;
      cmd.valid = 1;
      @(negedge clock);
      check("ready_before_accept", {31'd0, cmd.ready}, 1);
      @(posedge clock);
      #1 cmd.valid = 0;
      scramble();
      idx = 0; ready_bad = 0; got_done = 0;
      for (int k = 1; k <= lat + 4 && !got_done; k++) begin
         @(negedge clock);
         if (wren) begin
            if (idx < ex.size()) check("write", {19'd0, wraddress, data}, ex[idx]);
            else check("extra_write", 1, 0);
            idx++;
         end
         if (cmd.ready) ready_bad++;
         if (done) begin
            got_done = 1;
            check("done_latency", k, lat);
         end
      end
      if (!got_done) check("done_timeout", 0, 1);
      check("write_count", idx, ex.size());
      check("ready_low_while_busy", ready_bad, 0);
      @(negedge clock);
      check("ready_after_done", {30'd0, cmd.ready, busy}, 2);
      @(posedge clock);
      #1;
   endtask

   initial begin
      int nw, accepts, dones, bad;
      int wr[$];
      cmd.valid = 0;
      scramble();
      #2;
      @(negedge clock);
      check("rst_outputs", {16'd0, wraddress, data, wren, busy, done}, 0);
      check("rst_ready", {31'd0, cmd.ready}, 1);
      @(posedge clock);
      #1 reset = 0;

      run_cmd(OP_PIXEL, 5, 3, 0, 0, 1);
      check("pixel_hold_addr", {20'd0, wraddress}, 197);
      run_cmd(OP_RECT, 62, 10, 4, 2, 1);
      run_cmd(OP_RECT, 7, 7, 0, 5, 1);
      run_cmd(OP_RECT, 7, 7, 5, 0, 0);
      run_cmd(OP_NOP, 1, 1, 1, 1, 1);
      run_cmd(OP_RECT, 0, 0, 64, 64, 1);
      run_cmd(OP_RECT, 60, 61, 64, 64, 0);
      run_cmd(OP_CLEAR, 9, 9, 3, 3, 0);

      // abort a 4x4 fill after its tenth pixel
      cmd.op = OP_RECT; cmd.x = 10; cmd.y = 10; cmd.w = 4; cmd.h = 4; cmd.color = 1;
      cmd.valid = 1;
      @(posedge clock);
      #1 cmd.valid = 0;
      nw = 0;
      for (int k = 0; k < 40 && nw < 10; k++) begin
         @(negedge clock);
         if (wren) nw++;
      end
      check("abort_reached_pixel10", nw, 10);
      #2 reset = 1;
      #1;
      check("abort_outputs", {29'd0, wren, busy, done}, 0);
      check("abort_ready", {31'd0, cmd.ready}, 1);
      @(negedge clock);
      reset = 0;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         if (wren || done || busy) bad++;
      end
      check("abort_quiet", bad, 0);
      @(posedge clock);
      #1;
      run_cmd(OP_PIXEL, 63, 63, 0, 0, 1);

      // two pixels with valid held high across both
      cmd.op = OP_PIXEL; cmd.x = 1; cmd.y = 2; cmd.color = 1; cmd.valid = 1;
      @(posedge clock);
      #1 cmd.x = 40; cmd.y = 50; cmd.color = 0;
      accepts = 1; dones = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (wren) wr.push_back({wraddress, data});
         if (done) dones++;
         if (cmd.ready && cmd.valid) accepts++;
         @(posedge clock);
         #1 if (accepts == 2) cmd.valid = 0;
      end
      check("b2b_accepts", accepts, 2);
      check("b2b_dones", dones, 2);
      check("b2b_count", wr.size(), 2);
      if (wr.size() == 2) begin
         check("b2b_first", wr[0], (2 * 64 + 1) * 2 + 1);
         check("b2b_second", wr[1], (50 * 64 + 40) * 2);
      end

      for (int i = 0; i < 40; i++) begin
         logic [1:0] op;
         op = $urandom_range(0, 19) == 0 ? OP_CLEAR : 2'($urandom_range(0, 2));
         run_cmd(op, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 64),
                 $urandom_range(0, 64), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
